// File: rtl/regfile_wb_queue.sv
// Register file fronted by a DEPTH-entry write-back queue; writes retire one per
// cycle and both read ports forward from the incoming write and the queue.
module regfile_wb_queue #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     hold,
    input  logic [ADDR_W-1:0]        rd_addr_a,
    output logic [DATA_W-1:0]        rd_data_a,
    input  logic [ADDR_W-1:0]        rd_addr_b,
    output logic [DATA_W-1:0]        rd_data_b,
    output logic [$clog2(DEPTH):0]   pend_count,
    output logic                     idle
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NREG  = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs   [NREG];
    logic [ADDR_W-1:0] r_q_addr [DEPTH];
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign wr_ready   = (r_count < CNT_W'(DEPTH));
    assign w_push     = wr_valid & wr_ready;
    assign w_pop      = ~hold & (r_count != '0);
    assign pend_count = r_count;
    assign idle       = (r_count == '0);

    // Newest value wins: incoming write, then youngest queued match, then array.
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        logic [PTR_W-1:0]  idx;
        v = r_regs[a];
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_q_addr[idx] == a)) begin
                v = r_q_data[idx];
            end
        end
        if (w_push && (wr_addr == a)) begin
            v = wr_data;
        end
        return v;
    endfunction

    assign rd_data_a = f_read(rd_addr_a);
    assign rd_data_b = f_read(rd_addr_b);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q_addr[i] <= '0;
                r_q_data[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_q_addr[r_tail] <= wr_addr;
                r_q_data[r_tail] <= wr_data;
                r_tail           <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_regs[r_q_addr[r_head]] <= r_q_data[r_head];
                r_head                   <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed vector table, hand sequences for
// duplicates/reset, then random traffic against a queue-based reference model.
module tb_regfile_wb_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        hold;
    logic [2:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [2:0]  rd_addr_b;
    logic [15:0] rd_data_b;
    logic [2:0]  pend_count;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .hold       (hold),
        .rd_addr_a  (rd_addr_a),
        .rd_data_a  (rd_data_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_b  (rd_data_b),
        .pend_count (pend_count),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        bit          rst;
        bit          wv;
        logic [2:0]  wa;
        logic [15:0] wd;
        bit          hold;
        logic [2:0]  ra;
        logic [2:0]  rb;
        bit          e_rdy;
        logic [15:0] e_ra;
        logic [15:0] e_rb;
        logic [2:0]  e_cnt;
        bit          e_idle;
    } vec_t;

    vec_t vt[16];

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_regs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit r, input bit wv, input logic [2:0] wa, input logic [15:0] wd,
                         input bit h, input logic [2:0] ra, input logic [2:0] rb);
        rst = r; wr_valid = wv; wr_addr = wa; wr_data = wd; hold = h;
        rd_addr_a = ra; rd_addr_b = rb;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_push();
        return wr_valid && (mq.size() < DEPTH);
    endfunction

    function automatic logic [15:0] m_read(input logic [2:0] a);
        if (m_push() && wr_addr == a) return wr_data;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == a) return mq[i].d;
        end
        return m_regs[a];
    endfunction

    // Applies the reference rules for one clock edge.
    task automatic m_edge();
        ent_t e;
        bit   p;
        p = m_push();
        if (!rst) begin
            mq.delete();
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        end else begin
            if (!hold && mq.size() > 0) begin
                m_regs[mq[0].a] = mq[0].d;
                void'(mq.pop_front());
            end
            if (p) begin
                e.a = wr_addr; e.d = wr_data;
                mq.push_back(e);
            end
        end
    endtask

    initial begin
        //        chk rst wv wa  wd        hold ra rb  rdy ra        rb        cnt idle
        vt[0]  = '{0, 0, 1, 3, 16'hFFFF, 0, 3, 0,  1, 16'h0000, 16'h0000, 0, 1};
        vt[1]  = '{0, 0, 1, 3, 16'hFFFF, 0, 3, 0,  1, 16'h0000, 16'h0000, 0, 1};
        vt[2]  = '{1, 1, 0, 3, 16'h0000, 0, 3, 5,  1, 16'h0000, 16'h0000, 0, 1};
        vt[3]  = '{1, 1, 1, 3, 16'hBEEF, 0, 3, 0,  1, 16'hBEEF, 16'h0000, 0, 1};
        vt[4]  = '{1, 1, 0, 0, 16'h0000, 0, 3, 3,  1, 16'hBEEF, 16'hBEEF, 1, 0};
        vt[5]  = '{1, 1, 0, 0, 16'h0000, 0, 3, 0,  1, 16'hBEEF, 16'h0000, 0, 1};
        vt[6]  = '{1, 1, 1, 1, 16'h1111, 1, 1, 2,  1, 16'h1111, 16'h0000, 0, 1};
        vt[7]  = '{1, 1, 1, 2, 16'h2222, 1, 1, 2,  1, 16'h1111, 16'h2222, 1, 0};
        vt[8]  = '{1, 1, 1, 3, 16'h3333, 1, 3, 1,  1, 16'h3333, 16'h1111, 2, 0};
        vt[9]  = '{1, 1, 1, 4, 16'h4444, 1, 4, 3,  1, 16'h4444, 16'h3333, 3, 0};
        vt[10] = '{1, 1, 1, 5, 16'h5555, 1, 5, 4,  0, 16'h0000, 16'h4444, 4, 0};
        vt[11] = '{1, 1, 0, 0, 16'h0000, 0, 1, 2,  0, 16'h1111, 16'h2222, 4, 0};
        vt[12] = '{1, 1, 0, 0, 16'h0000, 0, 1, 4,  1, 16'h1111, 16'h4444, 3, 0};
        vt[13] = '{1, 1, 0, 0, 16'h0000, 0, 5, 2,  1, 16'h0000, 16'h2222, 2, 0};
        vt[14] = '{1, 1, 0, 0, 16'h0000, 0, 3, 4,  1, 16'h3333, 16'h4444, 1, 0};
        vt[15] = '{1, 1, 0, 0, 16'h0000, 0, 4, 1,  1, 16'h4444, 16'h1111, 0, 1};

        // Reset, single write and fill/drain vectors.
        for (int i = 0; i < 16; i++) begin
            apply(vt[i].rst, vt[i].wv, vt[i].wa, vt[i].wd, vt[i].hold, vt[i].ra, vt[i].rb);
            @(negedge clk);
            if (vt[i].chk) begin
                check($sformatf("vec%0d wr_ready", i), 32'(wr_ready), 32'(vt[i].e_rdy));
                check($sformatf("vec%0d rd_data_a", i), 32'(rd_data_a), 32'(vt[i].e_ra));
                check($sformatf("vec%0d rd_data_b", i), 32'(rd_data_b), 32'(vt[i].e_rb));
                check($sformatf("vec%0d pend_count", i), 32'(pend_count), 32'(vt[i].e_cnt));
                check($sformatf("vec%0d idle", i), 32'(idle), 32'(vt[i].e_idle));
            end
            cyc();
        end

        // Duplicate addresses: youngest wins, concurrent push+pop keeps count.
        apply(1, 1, 5, 16'h0A0A, 1, 0, 5);
        @(negedge clk); check("dup fwd first", 32'(rd_data_b), 32'h0A0A);
        cyc();
        apply(1, 1, 5, 16'h0B0B, 1, 0, 5);
        @(negedge clk); check("dup fwd second", 32'(rd_data_b), 32'h0B0B);
        cyc();
        apply(1, 0, 0, 16'h0, 1, 0, 5);
        @(negedge clk);
        check("dup queued read", 32'(rd_data_b), 32'h0B0B);
        check("dup count 2", 32'(pend_count), 32'd2);
        cyc();
        apply(1, 1, 6, 16'h0C0C, 0, 6, 5);
        @(negedge clk);
        check("pushpop pre count", 32'(pend_count), 32'd2);
        check("pushpop fwd a", 32'(rd_data_a), 32'h0C0C);
        check("pushpop read b", 32'(rd_data_b), 32'h0B0B);
        cyc();
        apply(1, 0, 0, 16'h0, 1, 6, 5);
        @(negedge clk);
        check("pushpop post count", 32'(pend_count), 32'd2);
        check("dup after one retire", 32'(rd_data_b), 32'h0B0B);
        apply(1, 0, 0, 16'h0, 0, 6, 5);
        cyc(); cyc();
        @(negedge clk);
        check("dup drained count", 32'(pend_count), 32'd0);
        check("dup drained r5", 32'(rd_data_b), 32'h0B0B);
        check("drained r6", 32'(rd_data_a), 32'h0C0C);
        cyc();

        // Reset with three entries queued: nothing reaches the array.
        apply(1, 1, 0, 16'h1234, 1, 0, 0); cyc();
        apply(1, 1, 6, 16'h5678, 1, 0, 0); cyc();
        apply(1, 1, 7, 16'h9ABC, 1, 0, 0); cyc();
        @(negedge clk); check("pre-reset count", 32'(pend_count), 32'd3);
        apply(0, 0, 0, 16'h0, 0, 0, 0); cyc();
        apply(1, 0, 0, 16'h0, 0, 0, 0);
        @(negedge clk);
        check("mid reset count", 32'(pend_count), 32'd0);
        check("mid reset idle", 32'(idle), 32'd1);
        check("mid reset ready", 32'(wr_ready), 32'd1);
        cyc(); cyc();
        for (int i = 0; i < 8; i++) begin
            apply(1, 0, 0, 16'h0, 0, 3'(i), 3'(7 - i));
            @(negedge clk);
            check($sformatf("reset r%0d a", i), 32'(rd_data_a), 32'h0);
            check($sformatf("reset r%0d b", 7 - i), 32'(rd_data_b), 32'h0);
            cyc();
        end

        // Random traffic against the reference model, starting from reset.
        apply(0, 0, 0, 16'h0, 0, 0, 0);
        m_edge(); cyc();
        for (int c = 0; c < 10000; c++) begin
            apply(($urandom_range(0, 499) != 0), ($urandom_range(0, 9) < 7),
                  3'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            @(negedge clk);
            check("rnd wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
            check("rnd pend_count", 32'(pend_count), 32'(mq.size()));
            check("rnd idle", 32'(idle), 32'(mq.size() == 0));
            check("rnd rd_data_a", 32'(rd_data_a), 32'(m_read(rd_addr_a)));
            check("rnd rd_data_b", 32'(rd_data_b), 32'(m_read(rd_addr_b)));
            m_edge();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
